// File: rtl/cache_axi_pkg.sv
// Shared types and AXI-side constants for the cache line miss engine.
// Holds the FSM state enum and a line-alignment helper.
package cache_axi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB_ADDR,
      S_WB_DATA,
      S_WB_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } line_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [3:0] WSTRB_FULL     = 4'hF;
   localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

   // Clears the byte-in-line offset bits; words must be a power of two.
   function automatic logic [31:0] line_align(input logic [31:0] a, input int unsigned words);
      logic [31:0] w_mask;
      w_mask = (words * 32'd4) - 32'd1;
      return a & ~w_mask;
   endfunction

endpackage

// File: rtl/line_burst_engine_if.sv
// Bridge-side request/burst bundle between the line engine (master)
// and the sram-like/AXI bridge (slave).
interface line_burst_engine_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_awvalid;
   logic [3:0]  req_rid;
   logic [1:0]  burst_type;
   logic [7:0]  burst_len;
   logic [2:0]  burst_size;
   logic        burst_wlast;
   logic [3:0]  wstrb_ppl;
   logic        addr_ok;
   logic        data_ok;
   logic        wb_ok;
   logic [31:0] cpu_rdata;

   modport master (
      output req, wr, size, addr, wdata, addr_awvalid, req_rid, burst_type,
             burst_len, burst_size, burst_wlast, wstrb_ppl,
      input  addr_ok, data_ok, wb_ok, cpu_rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata, addr_awvalid, req_rid, burst_type,
             burst_len, burst_size, burst_wlast, wstrb_ppl,
      output addr_ok, data_ok, wb_ok, cpu_rdata
   );
endinterface

// File: rtl/line_burst_engine.sv
// Cache miss engine: optional dirty-victim INCR write burst, then an INCR
// read burst that refills the missing line and hands it back with done.
module line_burst_engine
   import cache_axi_pkg::*;
#(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] RID        = 4'b0000
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     miss_req,
   input  logic                     miss_dirty,
   input  logic [31:0]              miss_addr,
   input  logic [31:0]              victim_addr,
   input  logic [32*LINE_WORDS-1:0] victim_line,
   output logic                     busy,
   output logic                     done,
   output logic [32*LINE_WORDS-1:0] refill_line,
   line_burst_engine_if.master      bus
);

   localparam int            CW   = $clog2(LINE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

   line_state_e                 r_state, w_nxt_state;
   logic [CW-1:0]               r_cnt, w_nxt_cnt;
   logic [31:0]                 r_maddr, r_vaddr, r_addr;
   logic [31:0]                 w_maddr, w_vaddr, w_nxt_addr;
   logic [LINE_WORDS-1:0][31:0] r_vline, r_rline;
   logic                        r_req, r_wr, r_aw, r_done, r_busy;
   logic                        w_latch, w_rd_we;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_rd_we     = 1'b0;
      w_latch     = (r_state == S_IDLE) && miss_req;
      w_maddr     = w_latch ? line_align(miss_addr, LINE_WORDS) : r_maddr;
      w_vaddr     = w_latch ? line_align(victim_addr, LINE_WORDS) : r_vaddr;
      case (r_state)
         S_IDLE: if (miss_req) begin
            w_nxt_state = miss_dirty ? S_WB_ADDR : S_RD_ADDR;
            w_nxt_cnt   = '0;
         end
         S_WB_ADDR: if (bus.addr_ok) w_nxt_state = S_WB_DATA;
         S_WB_DATA: if (bus.data_ok) begin
            w_nxt_cnt = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               w_nxt_state = S_WB_RESP;
               w_nxt_cnt   = '0;
            end
         end
         S_WB_RESP: if (bus.wb_ok) w_nxt_state = S_RD_ADDR;
         S_RD_ADDR: if (bus.addr_ok) w_nxt_state = S_RD_DATA;
         S_RD_DATA: if (bus.data_ok) begin
            w_rd_we   = 1'b1;
            w_nxt_cnt = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               w_nxt_state = S_DONE;
               w_nxt_cnt   = '0;
            end
         end
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
      // Address only changes when entering an address phase.
      w_nxt_addr = r_addr;
      if (w_nxt_state == S_WB_ADDR) w_nxt_addr = w_vaddr;
      if (w_nxt_state == S_RD_ADDR) w_nxt_addr = w_maddr;
   end

   // Control outputs are flopped from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_maddr <= '0;
         r_vaddr <= '0;
         r_addr  <= '0;
         r_vline <= '0;
         r_rline <= '0;
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_aw    <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_maddr <= w_maddr;
         r_vaddr <= w_vaddr;
         r_addr  <= w_nxt_addr;
         if (w_latch) r_vline <= victim_line;
         if (w_rd_we) r_rline[r_cnt] <= bus.cpu_rdata;
         r_req   <= (w_nxt_state == S_WB_DATA) || (w_nxt_state == S_RD_ADDR);
         r_wr    <= (w_nxt_state == S_WB_ADDR) || (w_nxt_state == S_WB_DATA) ||
                    (w_nxt_state == S_WB_RESP);
         r_aw    <= (w_nxt_state == S_WB_ADDR);
         r_done  <= (w_nxt_state == S_DONE);
         r_busy  <= (w_nxt_state != S_IDLE);
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign refill_line      = r_rline;
   assign bus.req          = r_req;
   assign bus.wr           = r_wr;
   assign bus.size         = SRAM_SIZE_WORD;
   assign bus.addr         = r_addr;
   assign bus.wdata        = (r_state == S_WB_DATA) ? r_vline[r_cnt] : '0;
   assign bus.addr_awvalid = r_aw;
   assign bus.req_rid      = RID;
   assign bus.burst_type   = AXI_BURST_INCR;
   assign bus.burst_len    = 8'(LINE_WORDS - 1);
   assign bus.burst_size   = AXI_SIZE_WORD;
   assign bus.burst_wlast  = (r_state == S_WB_DATA) && (r_cnt == LAST);
   assign bus.wstrb_ppl    = WSTRB_FULL;

endmodule

// File: tb/tb_line_burst_engine.sv
// Randomized bench: a reactive bridge model feeds the engine, a monitor
// pops an expected-event scoreboard built from the line-miss rules.
module tb_line_burst_engine;
   localparam int LW  = 8;
   localparam int LBW = 32 * LW;
   localparam int EV_AW = 0, EV_W = 1, EV_AR = 2, EV_DONE = 3;

   typedef struct {
      int             kind;
      logic [LBW-1:0] data;
   } ev_t;

   logic           clk = 1'b0;
   logic           resetn;
   logic           miss_req, miss_dirty;
   logic [31:0]    miss_addr, victim_addr;
   logic [LBW-1:0] victim_line, refill_line;
   logic           busy, done;

   line_burst_engine_if bus();

   line_burst_engine #(.LINE_WORDS(LW), .RID(4'h0)) dut (
      .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_dirty(miss_dirty),
      .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_line(victim_line),
      .busy(busy), .done(done), .refill_line(refill_line), .bus(bus)
   );

   always #5 clk = ~clk;

   ev_t            exp_q[$];
   logic [31:0]    rd_q[$];
   int             n_chk = 0, n_fail = 0;
   int             dly_lo = 0, dly_hi = 3, gap_max = 3;
   bit             spur_idle = 0, spur_rd = 0, extra_beat = 0;
   bit             b_pend = 0, rd_act = 0;
   int             rd_taken = 0;
   logic [LBW-1:0] last_line = '0;

   task automatic chk(input string nm, input logic [LBW-1:0] got, input logic [LBW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic exp_ev(input int kind, input logic [LBW-1:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d with nothing expected", kind);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", LBW'(kind), LBW'(e.kind));
         chk($sformatf("event_data_k%0d", e.kind), data, e.data);
      end
   endtask

   // Reference: a line address is the byte address rounded down to a line.
   function automatic logic [31:0] align(input logic [31:0] a);
      return (a / 32'(LW * 4)) * 32'(LW * 4);
   endfunction

   function automatic logic [LBW-1:0] rand_line();
      logic [LBW-1:0] l;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic start_miss(input bit dirty, input logic [31:0] ma, input logic [31:0] va,
                             input logic [LBW-1:0] vl, input logic [LBW-1:0] rl);
      ev_t e;
      miss_req = 1'b1; miss_dirty = dirty; miss_addr = ma; victim_addr = va; victim_line = vl;
      if (dirty) begin
         e.kind = EV_AW; e.data = LBW'(align(va)); exp_q.push_back(e);
         for (int i = 0; i < LW; i++) begin
            e.kind = EV_W; e.data = LBW'({(i == LW - 1), vl[32*i +: 32]}); exp_q.push_back(e);
         end
      end
      e.kind = EV_AR;   e.data = LBW'(align(ma)); exp_q.push_back(e);
      e.kind = EV_DONE; e.data = rl;              exp_q.push_back(e);
      for (int i = 0; i < LW; i++) rd_q.push_back(rl[32*i +: 32]);
      last_line = rl;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 400) begin
         tick();
         n++;
         if (busy) miss_req = 1'b0;
         if (done) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, required one", n);
   endtask

   // Bridge model: responds to whichever phase the engine presents.
   initial begin : bridge
      int wcnt; bit armed; int w_beats; bit xtra;
      armed = 0; wcnt = 0; w_beats = 0; xtra = 0;
      bus.addr_ok = 0; bus.data_ok = 0; bus.wb_ok = 0; bus.cpu_rdata = '0;
      forever begin
         @(negedge clk);
         bus.addr_ok = 0; bus.data_ok = 0; bus.wb_ok = 0; bus.cpu_rdata = $urandom;
         if (!resetn) begin
            armed = 0; w_beats = 0; xtra = 0; b_pend = 0; rd_act = 0; rd_taken = 0;
            continue;
         end
         if (xtra) begin
            bus.data_ok = 1; xtra = 0;
         end else if (bus.addr_awvalid || bus.req || (bus.wr && b_pend) || rd_act) begin
            if (!armed) begin
               armed = 1;
               wcnt = ((bus.wr && bus.req) || rd_act) ? $urandom_range(gap_max, 0)
                                                      : $urandom_range(dly_hi, dly_lo);
            end
            if (wcnt > 0) begin
               wcnt--;
               if (spur_rd && bus.req && !bus.wr) bus.data_ok = 1;
            end else begin
               armed = 0;
               if (bus.addr_awvalid) bus.addr_ok = 1;
               else if (bus.wr && bus.req) begin
                  bus.data_ok = 1;
                  w_beats++;
                  if (w_beats == LW) begin w_beats = 0; b_pend = 1; end
               end else if (bus.wr) begin
                  bus.wb_ok = 1; b_pend = 0;
               end else if (bus.req) begin
                  bus.addr_ok = 1; rd_act = 1; rd_taken = 0;
               end else begin
                  bus.data_ok = 1;
                  if (rd_q.size() > 0) bus.cpu_rdata = rd_q.pop_front();
                  rd_taken++;
                  if (rd_taken == LW) begin rd_act = 0; xtra = extra_beat; end
               end
            end
         end else if (spur_idle && !busy) bus.wb_ok = 1;
      end
   end

   initial begin : monitor
      logic [31:0] pw; bit pp;
      pp = 0; pw = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!resetn) begin pp = 0; continue; end
         if (bus.wr && bus.req) begin
            if (pp) chk("wdata_stable", LBW'(bus.wdata), LBW'(pw));
            pp = !bus.data_ok;
            pw = bus.wdata;
         end else pp = 0;
         if (bus.addr_awvalid || (bus.req && !bus.wr && bus.addr_ok))
            chk("burst_consts", LBW'({bus.size, bus.burst_type, bus.burst_len, bus.burst_size,
                                      bus.wstrb_ppl, bus.req_rid}),
                LBW'({2'b10, 2'b01, 8'(LW - 1), 3'b010, 4'hF, 4'h0}));
         if (bus.addr_awvalid && bus.addr_ok) exp_ev(EV_AW, LBW'(bus.addr));
         if (bus.wr && bus.req && bus.data_ok) exp_ev(EV_W, LBW'({bus.burst_wlast, bus.wdata}));
         if (bus.req && !bus.wr && bus.addr_ok) begin
            chk("ar_after_b", LBW'(b_pend), LBW'(0));
            exp_ev(EV_AR, LBW'(bus.addr));
         end
         if (done) exp_ev(EV_DONE, refill_line);
      end
   end

   initial begin : stim
      int n; logic [LBW-1:0] l; bit hit;
      resetn = 0; miss_req = 0; miss_dirty = 0; miss_addr = '0; victim_addr = '0; victim_line = '0;
      repeat (3) tick();
      chk("reset_ctrl", LBW'({busy, done, bus.req, bus.wr, bus.addr_awvalid, bus.burst_wlast}), '0);
      chk("reset_addr_wdata", LBW'({bus.addr, bus.wdata}), '0);
      chk("reset_refill", refill_line, '0);
      resetn = 1;
      tick();

      // Clean miss with fixed timing: addr_ok one cycle late, no beat gaps.
      dly_lo = 1; dly_hi = 1; gap_max = 0;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = 32'hA0 + 32'(i);
      start_miss(0, 32'h1000_0024, 32'h0, '0, l);
      wait_done(n);
      chk("clean_latency", LBW'(n), LBW'(3 + LW));

      // Dirty miss with stalls and a stray beat after the last read.
      dly_lo = 0; dly_hi = 3; gap_max = 3; extra_beat = 1;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = 32'hB0 + 32'(i);
      start_miss(1, $urandom, 32'h2000_0040, l, rand_line());
      wait_done(n);
      repeat (3) tick();
      extra_beat = 0;
      chk("refill_hold", refill_line, last_line);

      // miss_req pulsed mid-operation, then a back-to-back miss after done.
      start_miss(1, $urandom, $urandom, rand_line(), rand_line());
      tick();
      miss_req = 0;
      repeat (3) tick();
      miss_req = 1; miss_dirty = 0; miss_addr = $urandom; victim_addr = $urandom;
      tick();
      miss_req = 0;
      wait_done(n);
      start_miss(0, $urandom, $urandom, rand_line(), rand_line());
      wait_done(n);
      tick();
      chk("b2b_idle", LBW'(busy), LBW'(0));

      // Reset while the refill is at beat 3.
      dly_lo = 0; dly_hi = 2; gap_max = 1;
      start_miss(0, $urandom, $urandom, '0, rand_line());
      hit = 0;
      for (int k = 0; k < 300 && !hit; k++) begin
         tick();
         if (busy) miss_req = 0;
         if (rd_act && rd_taken == 3) hit = 1;
      end
      chk("reach_beat3", LBW'(hit), LBW'(1));
      resetn = 0;
      #1;
      chk("rst_mid_ctrl", LBW'({bus.req, bus.wr, busy, done}), '0);
      chk("rst_mid_refill", refill_line, '0);
      exp_q.delete();
      rd_q.delete();
      miss_req = 0;
      repeat (2) tick();
      resetn = 1;
      tick();
      start_miss(1, $urandom, $urandom, rand_line(), rand_line());
      wait_done(n);

      // Stray handshakes: wb_ok while idle, data_ok while the AR is pending.
      tick();
      spur_idle = 1;
      repeat (4) tick();
      spur_idle = 0;
      chk("spur_idle_busy", LBW'(busy), LBW'(0));
      chk("spur_idle_refill", refill_line, last_line);
      spur_rd = 1; dly_lo = 2; dly_hi = 3;
      start_miss(0, $urandom, $urandom, '0, rand_line());
      wait_done(n);
      spur_rd = 0;

      for (int r = 0; r < 8; r++) begin
         dly_lo = 0; dly_hi = 3; gap_max = $urandom_range(3, 0);
         start_miss($urandom_range(1, 0) == 1, $urandom, $urandom, rand_line(), rand_line());
         wait_done(n);
         if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) tick();
      end

      for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick();
      repeat (2) tick();
      chk("queue_drained", LBW'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/line_burst_engine.md
Name: line_burst_engine

Overview:
- Cache-line miss engine directly upstream of the sram-like/AXI bridge.
- On a cache miss it optionally writes back the dirty victim line as one INCR burst, then refills the missing line as one INCR read burst.
- It drives the bridge's req/wr/burst controls, counts addr_ok/data_ok/wb_ok, and returns the assembled line to the cache.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16.
- RID, 4'b0000, AXI read ID driven on req_rid.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- miss_req  in  1  cache requests a line operation; sampled only in IDLE
- miss_dirty  in  1  victim line must be written back first
- miss_addr  in  32  missing line address; low log2(LINE_WORDS)+2 bits ignored
- victim_addr  in  32  victim line address; low bits ignored
- victim_line  in  32*LINE_WORDS  victim data; word 0 in bits [31:0]
- busy  out  1  engine not in IDLE
- done  out  1  one-cycle pulse: refill_line valid
- refill_line  out  32*LINE_WORDS  refilled line; word i in bits [32i+31:32i]
- req  out  1  bridge request
- wr  out  1  bridge write select
- size  out  2  constant 2'b10
- addr  out  32  line-aligned burst address
- wdata  out  32  current write beat
- addr_awvalid  out  1  AW valid to bridge
- req_rid  out  4  = RID
- burst_type  out  2  constant 2'b01 (INCR)
- burst_len  out  8  constant LINE_WORDS-1
- burst_size  out  3  constant 3'b010
- burst_wlast  out  1  current write beat is the last
- wstrb_ppl  out  4  constant 4'hF
- addr_ok  in  1  bridge address handshake
- data_ok  in  1  bridge per-beat data handshake
- wb_ok  in  1  bridge write-response (B) handshake
- cpu_rdata  in  32  read beat data

Behaviour:
- Reset (resetn low, any time, asynchronous): state=IDLE, beat counter=0, req=wr=addr_awvalid=burst_wlast=done=busy=0, addr=0, wdata=0, refill_line=0. Any burst in flight is abandoned; no bridge-side cleanup.
- States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If miss_req=1, latch aligned miss_addr, aligned victim_addr and victim_line, and clear the counter.
  - Next state is WB_ADDR if miss_dirty=1, else RD_ADDR.
  - The first bridge request appears one cycle after miss_req.
- WB_ADDR: wr=1, addr_awvalid=1, req=0, addr=latched victim address. Hold until addr_ok, then go to WB_DATA.
- WB_DATA:
  - wr=1, req=1, addr_awvalid=0.
  - wdata = latched word[cnt]; burst_wlast = (cnt==LINE_WORDS-1).
  - Each data_ok increments cnt.
  - On data_ok with the last beat, go to WB_RESP and clear cnt.
  - wdata must not change while a beat is pending.
- WB_RESP: wr=1, req=0. On wb_ok, go to RD_ADDR.
- RD_ADDR: wr=0, req=1, addr=latched miss address. On addr_ok, go to RD_DATA; req=0 from that cycle on, so only one AR is issued.
- RD_DATA:
  - wr=0, req=0.
  - Each data_ok writes cpu_rdata into refill_line word[cnt] and increments cnt.
  - The last beat goes to DONE.
  - Beats beyond LINE_WORDS are not expected; if they occur they are ignored.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - refill_line holds its value until the next refill writes it.
- Counter: width log2(LINE_WORDS). It wraps to 0 naturally after the last beat; the FSM also clears it explicitly.
- busy=1 in every state except IDLE.
- miss_req in any non-IDLE state is ignored; the cache must hold it until done.
- miss_req high in the cycle after done starts a new operation.
- addr_ok/data_ok/wb_ok arriving in a state that does not expect them are ignored.
- Registered vs combinational outputs:
  - All control outputs are registered from state.
  - wdata and burst_wlast are muxed from registered state and registered data.

Decomposition:
- Shared package cache_axi_pkg holds:
  - line_state_e, the FSM enum;
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_WORD=3'b010, WSTRB_FULL=4'hF.
- No sub-module; the line buffer is the only storage and is inline.

Test Plan:
- Clean miss, addr 0x1000_0024, miss_dirty=0, addr_ok 2 cycles later, 8 data_ok beats 0xA0..0xA7 -> addr=0x1000_0020, wr=0, burst_len=7; refill_line words 0..7 = 0xA0..0xA7; done pulses once; total operation 1+addr+beats+1 cycles.
- Dirty miss, victim 0x2000_0040 with words 0xB0..0xB7 -> AW first with addr=0x2000_0040; wdata steps 0xB0..0xB7; burst_wlast only on 0xB7; AR only after wb_ok.
- data_ok stalls (random 0-3 gaps) during WB_DATA -> wdata stable while a beat is pending; no beat skipped or repeated.
- miss_req pulsed while busy -> ignored; a back-to-back miss_req in the cycle after done starts a second burst.
- resetn dropped mid RD_DATA at beat 3 -> immediately req=0, busy=0, refill_line=0; the next miss completes normally.
- Spurious data_ok in RD_ADDR and spurious wb_ok in IDLE -> no state or counter change.
